// File: rtl/sign_extender.sv
// Registered 16-to-32 bit immediate extension unit with valid flag and sign output.
// Optional BRANCH mode (3'b101) is compiled in when SIGN_EXTENDER_BRANCH_EN is defined.
module sign_extender (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [2:0]  mode,
  input  logic        in_valid,
  output logic [31:0] b,
  output logic        out_valid,
  output logic        neg
);

  typedef enum logic [2:0] {
    MODE_SEXT16 = 3'b000,
    MODE_ZEXT16 = 3'b001,
    MODE_LUI    = 3'b010,
    MODE_SEXT8  = 3'b011,
    MODE_ZEXT8  = 3'b100,
    MODE_BRANCH = 3'b101
  } ext_mode_t;

  logic [31:0] next_b;

  // Reserved encodings, and BRANCH when not compiled in, fall back to SEXT16.
  always_comb begin
    next_b = {{16{a[15]}}, a};
    case (ext_mode_t'(mode))
      MODE_ZEXT16: next_b = {16'h0000, a};
      MODE_LUI:    next_b = {a, 16'h0000};
      MODE_SEXT8:  next_b = {{24{a[7]}}, a[7:0]};
      MODE_ZEXT8:  next_b = {24'h000000, a[7:0]};
`ifdef SIGN_EXTENDER_BRANCH_EN
      MODE_BRANCH: next_b = {{14{a[15]}}, a, 2'b00};
`endif
      default:     next_b = {{16{a[15]}}, a};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b         <= 32'h0000_0000;
      neg       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        b   <= next_b;
        neg <= next_b[31];
      end
    end
  end

endmodule

// File: tb/tb_sign_extender.sv
// Directed self-checking bench for sign_extender; mode 3'b101 expectation
// follows SIGN_EXTENDER_BRANCH_EN.
module tb_sign_extender;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [2:0]  mode;
  logic        in_valid;
  logic [31:0] b;
  logic        out_valid;
  logic        neg;

  int n_compared;
  int n_mismatched;

  sign_extender dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .mode      (mode),
    .in_valid  (in_valid),
    .b         (b),
    .out_valid (out_valid),
    .neg       (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge, then sample 1 time unit after the next rising edge.
  task automatic step(input logic [15:0] a_i, input logic [2:0] mode_i, input logic valid_i);
    @(negedge clk);
    a        = a_i;
    mode     = mode_i;
    in_valid = valid_i;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [33:0] exp_v;
    step(16'h8abc, 3'b000, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    exp_v = {32'h0, 1'b0, 1'b0};
    n_compared++;
    if ({b, neg, out_valid} !== exp_v) begin
      n_mismatched++;
      $display("[TB] FAIL async_reset: got %h want %h", {b, neg, out_valid}, exp_v);
    end
    in_valid = 1'b1;
    a        = 16'hffff;
    @(posedge clk);
    #1;
    n_compared++;
    if ({b, neg, out_valid} !== exp_v) begin
      n_mismatched++;
      $display("[TB] FAIL valid_during_reset: got %h want %h", {b, neg, out_valid}, exp_v);
    end
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    step(16'h7abc, 3'b000, 1'b1);
    exp_v = {32'h0000_7abc, 1'b0, 1'b1};
    n_compared++;
    if ({b, neg, out_valid} !== exp_v) begin
      n_mismatched++;
      $display("[TB] FAIL first_capture: got %h want %h", {b, neg, out_valid}, exp_v);
    end
  endtask

  task automatic test_modes();
    logic [15:0] va  [8];
    logic [2:0]  vm  [8];
    logic [31:0] vb  [8];
    va[0] = 16'h8abc; vm[0] = 3'b000; vb[0] = 32'hffff_8abc;
    va[1] = 16'h8abc; vm[1] = 3'b001; vb[1] = 32'h0000_8abc;
    va[2] = 16'h8abc; vm[2] = 3'b010; vb[2] = 32'h8abc_0000;
    va[3] = 16'h12bc; vm[3] = 3'b011; vb[3] = 32'hffff_ffbc;
    va[4] = 16'h12bc; vm[4] = 3'b100; vb[4] = 32'h0000_00bc;
`ifdef SIGN_EXTENDER_BRANCH_EN
    va[5] = 16'h8abc; vm[5] = 3'b101; vb[5] = 32'hfffe_2af0;
`else
    va[5] = 16'h8abc; vm[5] = 3'b101; vb[5] = 32'hffff_8abc;
`endif
    va[6] = 16'h8abc; vm[6] = 3'b111; vb[6] = 32'hffff_8abc;
    va[7] = 16'h127f; vm[7] = 3'b011; vb[7] = 32'h0000_007f;
    for (int i = 0; i < 8; i++) begin
      step(va[i], vm[i], 1'b1);
      n_compared++;
      if ({b, neg, out_valid} !== {vb[i], vb[i][31], 1'b1}) begin
        n_mismatched++;
        $display("[TB] FAIL mode_%0d a=%h mode=%b: got b=%h neg=%b ov=%b want b=%h neg=%b ov=1",
                 i, va[i], vm[i], b, neg, out_valid, vb[i], vb[i][31]);
      end
    end
  endtask

  task automatic test_hold();
    step(16'h8abc, 3'b000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(16'h0001, 3'b001, 1'b0);
      n_compared++;
      if ({b, neg, out_valid} !== {32'hffff_8abc, 1'b1, 1'b0}) begin
        n_mismatched++;
        $display("[TB] FAIL hold_%0d: got b=%h neg=%b ov=%b want b=ffff8abc neg=1 ov=0",
                 i, b, neg, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    step(16'h0001, 3'b000, 1'b1);
    n_compared++;
    if ({b, neg, out_valid} !== {32'h0000_0001, 1'b0, 1'b1}) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_first: got b=%h neg=%b ov=%b want b=00000001 neg=0 ov=1",
               b, neg, out_valid);
    end
    step(16'hffff, 3'b000, 1'b1);
    n_compared++;
    if ({b, neg, out_valid} !== {32'hffff_ffff, 1'b1, 1'b1}) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_second: got b=%h neg=%b ov=%b want b=ffffffff neg=1 ov=1",
               b, neg, out_valid);
    end
  endtask

  task automatic test_reset_mid_stream();
    step(16'h8000, 3'b010, 1'b1);
    @(negedge clk);
    a    = 16'h4444;
    mode = 3'b001;
    #1;
    rst = 1'b1;
    #1;
    n_compared++;
    if ({b, neg, out_valid} !== 34'h0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_mid_stream: got b=%h neg=%b ov=%b want all zero",
               b, neg, out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    step(16'h4444, 3'b001, 1'b1);
    n_compared++;
    if ({b, neg, out_valid} !== {32'h0000_4444, 1'b0, 1'b1}) begin
      n_mismatched++;
      $display("[TB] FAIL after_mid_reset: got b=%h neg=%b ov=%b want b=00004444 neg=0 ov=1",
               b, neg, out_valid);
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst      = 1'b0;
    a        = 16'h0;
    mode     = 3'b000;
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_compared++;
    if ({b, neg, out_valid} !== 34'h0) begin
      n_mismatched++;
      $display("[TB] FAIL power_on_reset: got b=%h neg=%b ov=%b want all zero", b, neg, out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_modes();
    test_hold();
    test_back_to_back();
    test_reset_mid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
